// File: rtl/mesm6_pkg.sv
// Shared types and constants for the MESM-6 instruction prefetch unit.
package mesm6_pkg;

   localparam int MESM6_WORD_W = 48;
   localparam int MESM6_HALF_W = 24;
   localparam int MESM6_AW     = 15;

   // Half-word PC at the default word-address width.
   typedef logic [MESM6_AW:0] mesm6_pc_t;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_FETCH,
      PF_DISCARD
   } pf_state_t;

endpackage

// File: rtl/mesm6_prefetch_fifo.sv
// DEPTH-word circular buffer for the prefetch unit; pointers carry one extra wrap bit.
module mesm6_prefetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 48,
   localparam int PW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [PW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr[PW-2:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[PW-2:0]];
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

endmodule

// File: rtl/mesm6_prefetch.sv
// MESM-6 instruction prefetch: fetch-ahead word buffer feeding half-word opcodes.
// Optional statistics counters are enabled with `define MESM6_PREFETCH_STATS_EN.
module mesm6_prefetch
   import mesm6_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    redirect,
   input  logic [AW:0]             redirect_pc,
   output logic                    op_valid,
   input  logic                    op_take,
   output logic [MESM6_HALF_W-1:0] op_word,
   output logic [AW:0]             op_pc,
   output logic                    ibus_fetch,
   output logic [AW-1:0]           ibus_addr,
   input  logic [MESM6_WORD_W-1:0] ibus_input,
   input  logic                    ibus_done
`ifdef MESM6_PREFETCH_STATS_EN
   ,
   output logic [31:0]             stat_fetches,
   output logic [31:0]             stat_flushes
`endif
);

   localparam int PW = $clog2(DEPTH) + 1;

   pf_state_t               state;
   pf_state_t               state_n;
   logic [AW-1:0]           fetch_addr;
   logic [AW-1:0]           fetch_addr_n;
   logic [AW-1:0]           addr_n;
   logic                    fetch_n;
   logic                    hf;
   logic [AW:0]             pc;
   logic                    push;
   logic                    pop;
   logic                    take_ok;
   logic                    full;
   logic                    empty;
   logic [PW-1:0]           count;
   logic [PW:0]             occ_after;
   logic [MESM6_WORD_W-1:0] rdata;

   mesm6_prefetch_fifo #(
      .DEPTH (DEPTH),
      .W     (MESM6_WORD_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata (ibus_input),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign op_valid = !empty;
   assign op_word  = hf ? rdata[MESM6_HALF_W-1:0] : rdata[MESM6_WORD_W-1:MESM6_HALF_W];
   assign op_pc    = pc;
   assign take_ok  = op_take && !empty && !redirect;
   assign pop      = take_ok && hf;

   always_comb begin
      state_n      = state;
      fetch_addr_n = fetch_addr;
      addr_n       = ibus_addr;
      fetch_n      = ibus_fetch;
      push         = 1'b0;
      // Occupancy after this edge, used to decide whether another word may be in flight.
      occ_after    = {1'b0, count} + (PW+1)'(1) - (PW+1)'(pop);
      if (redirect) fetch_addr_n = redirect_pc[AW:1];
      unique case (state)
         PF_IDLE: begin
            if (redirect || !full) begin
               state_n = PF_FETCH;
               fetch_n = 1'b1;
               addr_n  = fetch_addr_n;
            end
         end
         PF_FETCH: begin
            if (redirect) begin
               if (ibus_done) addr_n  = fetch_addr_n;
               else           state_n = PF_DISCARD;
            end else if (ibus_done) begin
               push         = 1'b1;
               fetch_addr_n = fetch_addr + AW'(1);
               if (occ_after < (PW+1)'(DEPTH)) begin
                  addr_n = fetch_addr_n;
               end else begin
                  state_n = PF_IDLE;
                  fetch_n = 1'b0;
               end
            end
         end
         PF_DISCARD: begin
            if (ibus_done) begin
               state_n = PF_FETCH;
               addr_n  = fetch_addr_n;
            end
         end
         default: begin
            state_n = PF_IDLE;
            fetch_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= PF_IDLE;
         fetch_addr <= '0;
         ibus_addr  <= '0;
         ibus_fetch <= 1'b0;
      end else begin
         state      <= state_n;
         fetch_addr <= fetch_addr_n;
         ibus_addr  <= addr_n;
         ibus_fetch <= fetch_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hf <= 1'b0;
         pc <= '0;
      end else if (redirect) begin
         hf <= redirect_pc[0];
         pc <= redirect_pc;
      end else if (take_ok) begin
         hf <= !hf;
         pc <= pc + (AW+1)'(1);
      end
   end

`ifdef MESM6_PREFETCH_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_fetches <= '0;
         stat_flushes <= '0;
      end else begin
         if (ibus_done && state != PF_IDLE && stat_fetches != '1) stat_fetches <= stat_fetches + 32'd1;
         if (redirect && stat_flushes != '1) stat_flushes <= stat_flushes + 32'd1;
      end
   end
`endif

endmodule

// File: doc/mesm6_prefetch.md
Name: mesm6_prefetch

Overview:
Parametrised instruction prefetch unit for the MESM-6 core. It replaces the single-word opcode cache with a DEPTH-word circular buffer that fetches ahead on the instruction bus. It hands 24-bit half-word opcodes to the microcode sequencer, left half first. Taken jumps redirect it through a flush.

Parameters:
DEPTH, 4, buffer depth in 48-bit words; power of two, at least 2.
AW, 15, word address width; the PC is AW+1 bits at half-word granularity.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
redirect  in  1  load new PC and flush buffer
redirect_pc  in  AW+1  target PC; bit 0 selects half (0 = left [47:24])
op_valid  out  1  op_word/op_pc are valid
op_take  in  1  consume current half-word; ignored when op_valid=0
op_word  out  24  current opcode
op_pc  out  AW+1  half-word PC of op_word
ibus_fetch  out  1  fetch request; held until ibus_done
ibus_addr  out  AW  fetch word address; stable while ibus_fetch=1
ibus_input  in  48  fetched word, valid with ibus_done
ibus_done  in  1  fetch completed this cycle

Behaviour:
- Reset values: op_valid=0, ibus_fetch=0, ibus_addr=0, op_pc=0, buffer empty, state IDLE. Reset mid-fetch drops the request immediately.
- Buffer: DEPTH words with rd_ptr/wr_ptr one bit wider than log2(DEPTH), plus a half flag hf.
  - op_word = hf ? word[rd][23:0] : word[rd][47:24].
  - op_valid = buffer not empty.
- Take rules:
  - op_take with hf=0 sets hf=1.
  - op_take with hf=1 pops the word and clears hf.
  - op_pc increments by 1 on every take and wraps modulo 2^(AW+1).
- FSM states: IDLE, FETCH, DISCARD.
  - IDLE -> FETCH when the buffer is not full (counting words already in flight). ibus_fetch rises on that edge with ibus_addr = fetch_addr.
  - FETCH, ibus_done=1: push ibus_input and increment fetch_addr (wraps at 2^AW). Re-enter FETCH next cycle if there is still room, otherwise go to IDLE. There are no idle bubbles between back-to-back fetches.
  - FETCH, redirect=1 and ibus_done=0: go to DISCARD. The bus cannot abort, so ibus_fetch stays high with the old address.
  - DISCARD, ibus_done=1: drop the data and go to FETCH at the new fetch_addr on the next cycle.
- Redirect:
  - Flushes the buffer in the same edge.
  - Sets fetch_addr = redirect_pc[AW:1], hf = redirect_pc[0], op_pc = redirect_pc.
  - op_valid is 0 the cycle after a redirect.
- Redirect with ibus_done in the same cycle: the returned word is discarded and the new fetch starts next cycle.
- Redirect together with op_take: redirect wins and the take is ignored.
- Latency from redirect with the bus idle:
  - ibus_fetch is asserted in cycle +1.
  - op_valid is asserted the cycle after ibus_done.
  - No combinational path from ibus_input to op_word.
- Full buffer: no request is issued. A pop and a push in the same cycle are both honoured, and the pointers stay consistent.
- Empty buffer: op_take is ignored, with no pointer or op_pc change.
- Flush when hf=1 at an odd redirect target: the left half of the first fetched word is skipped.

Optional Feature:
MESM6_PREFETCH_STATS_EN.
- Defined: adds outputs stat_fetches[31:0] (count of accepted words, including discarded ones) and stat_flushes[31:0] (count of redirects). Both reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Package mesm6_pkg gets:
  - the FSM state enum (PF_IDLE, PF_FETCH, PF_DISCARD);
  - constants MESM6_WORD_W=48 and MESM6_HALF_W=24;
  - a typedef for the half-word PC.
- Sub-module mesm6_prefetch_fifo: DEPTH-word circular buffer with push, pop, flush, full, empty, count and a read-data port. The FSM, half-word selection and op_pc stay in the top module.

Test Plan:
1. Reset, then redirect to PC 0o200 with ibus_done returning one cycle after each request -> ibus_addr goes 0o100, 0o101, ...; op_word yields the left then right half of each word; op_pc goes 0o200, 0o201, ...
2. DEPTH=4, op_take held 0 -> exactly 4 fetches, then ibus_fetch stays 0. One word consumed (two takes) -> exactly one more fetch.
3. Redirect to 0o301 while a fetch at 0o100 is pending, with ibus_done 3 cycles later -> that word is dropped, the next ibus_addr is 0o140, and the first op_word is the right half with op_pc=0o301.
4. Redirect, op_take and ibus_done asserted in the same cycle -> the take is ignored, the word is discarded, and the fetch at the new address starts next cycle.
5. Redirect to PC 0o177776 (AW=15) -> ibus_addr goes 0o77777 then 0o00000, and op_pc wraps to 0.
6. Assert reset asynchronously in the middle of a fetch -> ibus_fetch and op_valid drop without waiting for a clock edge. With MESM6_PREFETCH_STATS_EN defined, both counters read 0.
